// File: rtl/cylon_pkg.sv
// ============================================================================
//  Module      : cylon_pkg
//  Description : Shared state encoding and default sizing for the cylon scanner.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package cylon_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SWEEP_UP = 2'd1,
        SWEEP_DN = 2'd2
    } state_t;

    localparam int c_TICK_COUNT_DEFAULT = 10000;
    localparam int c_NUM_POS_DEFAULT    = 8;

endpackage

`default_nettype wire

// File: rtl/cylon_prescaler.sv
// ============================================================================
//  Module      : cylon_prescaler
//  Description : Free-running step prescaler; wrap marks the last cycle of a step.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module cylon_prescaler
    import cylon_pkg::*;
#(
    parameter int TICK_COUNT = c_TICK_COUNT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic wrap
);

    localparam int              c_W    = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam logic [c_W-1:0]  c_LAST = c_W'(TICK_COUNT - 1);

    logic [c_W-1:0] r_cnt;

    assign wrap = en && (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= wrap ? '0 : r_cnt + c_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/cylon_scan_ctrl.sv
// ============================================================================
//  Module      : cylon_scan_ctrl
//  Description : Back-and-forth LED scanner with pause/resume and registered outputs.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module cylon_scan_ctrl
    import cylon_pkg::*;
#(
    parameter int TICK_COUNT = c_TICK_COUNT_DEFAULT,
    parameter int NUM_POS    = c_NUM_POS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic [3:0]         pos,
    output logic [NUM_POS-1:0] pattern,
    output logic [0:1]         pair,
    output logic               sel,
    output logic               tick,
    output logic               dir
);

    localparam logic [3:0]         c_LAST_POS = 4'(NUM_POS - 1);
    localparam logic [3:0]         c_HALF     = 4'(NUM_POS / 2);
    localparam logic [NUM_POS-1:0] c_ONE      = NUM_POS'(1);

    state_t             r_state;
    logic [3:0]         r_pos;
    logic [NUM_POS-1:0] r_pattern;
    logic [0:1]         r_pair;
    logic               r_sel;
    logic               r_tick;
    logic               r_dir;

    logic               w_sweeping;
    logic               w_clr;
    logic               w_wrap;
    logic               w_step;
    logic [3:0]         w_pos_nxt;

    assign w_sweeping = (r_state == SWEEP_UP) || (r_state == SWEEP_DN);
    assign w_clr      = !w_sweeping || !run;
    // A pause request wins over a coincident wrap: no move, no tick.
    assign w_step     = w_wrap && run;

    cylon_prescaler #(
        .TICK_COUNT (TICK_COUNT)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .en    (w_sweeping),
        .wrap  (w_wrap)
    );

    always_comb begin
        w_pos_nxt = r_pos;
        if (w_step) begin
            w_pos_nxt = (r_state == SWEEP_DN) ? r_pos - 4'd1 : r_pos + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pos     <= 4'd0;
            r_pattern <= c_ONE;
            r_pair    <= 2'b10;
            r_sel     <= 1'b0;
            r_tick    <= 1'b0;
            r_dir     <= 1'b0;
        end else begin
            // Image outputs are derived from the next position so they never lag pos.
            r_pos     <= w_pos_nxt;
            r_pattern <= c_ONE << w_pos_nxt;
            r_pair[0] <= (w_pos_nxt <  c_HALF);
            r_pair[1] <= (w_pos_nxt >= c_HALF);
            r_tick    <= w_step;
            case (r_state)
                IDLE: begin
                    r_sel <= run;
                    if (run) begin
                        r_state <= r_dir ? SWEEP_DN : SWEEP_UP;
                    end
                end
                SWEEP_UP: begin
                    if (!run) begin
                        r_state <= IDLE;
                        r_sel   <= 1'b0;
                    end else if (w_step && (w_pos_nxt == c_LAST_POS)) begin
                        r_state <= SWEEP_DN;
                        r_dir   <= 1'b1;
                    end
                end
                SWEEP_DN: begin
                    if (!run) begin
                        r_state <= IDLE;
                        r_sel   <= 1'b0;
                    end else if (w_step && (w_pos_nxt == 4'd0)) begin
                        r_state <= SWEEP_UP;
                        r_dir   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_sel   <= 1'b0;
                end
            endcase
        end
    end

    assign pos     = r_pos;
    assign pattern = r_pattern;
    assign pair    = r_pair;
    assign sel     = r_sel;
    assign tick    = r_tick;
    assign dir     = r_dir;

endmodule

`default_nettype wire

// File: tb/tb_cylon_scan_ctrl.sv
// ============================================================================
//  Module      : tb_cylon_scan_ctrl
//  Description : Self-checking bench for cylon_scan_ctrl against a step-level model.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_cylon_scan_ctrl;

    localparam int TC = 4;
    localparam int NP = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          run   = 1'b0;
    logic          run2  = 1'b0;
    logic [3:0]    pos, pos2;
    logic [NP-1:0] pattern, pattern2;
    logic [0:1]    pair, pair2;
    logic          sel, sel2, tick, tick2, dir, dir2;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: position/direction plus cycles elapsed in the current step.
    int m_pos, m_dir, m_sel, m_tick, m_age;

    cylon_scan_ctrl #(.TICK_COUNT(TC), .NUM_POS(NP)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .pos(pos), .pattern(pattern),
        .pair(pair), .sel(sel), .tick(tick), .dir(dir)
    );

    cylon_scan_ctrl #(.TICK_COUNT(10000), .NUM_POS(NP)) dut_slow (
        .clk(clk), .rst_n(rst_n), .run(run2), .pos(pos2), .pattern(pattern2),
        .pair(pair2), .sel(sel2), .tick(tick2), .dir(dir2)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_dir = 0; m_sel = 0; m_tick = 0; m_age = 0;
    endtask

    task automatic model_edge(input logic r);
        m_tick = 0;
        if (!r) begin
            m_sel = 0;
            m_age = 0;
        end else if (m_sel == 0) begin
            m_sel = 1;
            m_age = 0;
        end else begin
            m_age++;
            if (m_age == TC) begin
                m_age  = 0;
                m_tick = 1;
                m_pos  = (m_dir != 0) ? m_pos - 1 : m_pos + 1;
                if (m_pos == NP - 1)  m_dir = 1;
                else if (m_pos == 0)  m_dir = 0;
            end
        end
    endtask

    task automatic check_all();
        check_eq("pos",     32'(pos),     32'(m_pos));
        check_eq("pattern", 32'(pattern), 32'(1) << m_pos);
        check_eq("pair",    32'(pair),    {30'd0, m_pos < NP/2, m_pos >= NP/2});
        check_eq("sel",     32'(sel),     32'(m_sel));
        check_eq("tick",    32'(tick),    32'(m_tick));
        check_eq("dir",     32'(dir),     32'(m_dir));
    endtask

    task automatic cycle(input logic r);
        @(negedge clk);
        run = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_all();
    endtask

    initial begin
        int n;
        int saved;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Continuous run: two full bounces.
        repeat (2 * (NP - 1) * TC + 2 * TC) cycle(1'b1);

        // Pause at pos 3 while sweeping up, then resume.
        n = 0;
        while (!(m_pos == 3 && m_dir == 0 && m_tick == 1) && n < 200) begin
            cycle(1'b1);
            n++;
        end
        check_eq("reach_pos3", 32'(n < 200), 32'd1);
        check_eq("pair_pos3",    32'(pair),    32'h2);
        check_eq("pattern_pos3", 32'(pattern), 32'h08);
        repeat (10) cycle(1'b0);
        cycle(1'b1);
        n = 0;
        while (tick !== 1'b1 && n < 20) begin
            cycle(1'b1);
            n++;
        end
        check_eq("resume_latency", 32'(n), 32'(TC));
        check_eq("pair_pos4",    32'(pair),    32'h1);
        check_eq("pattern_pos4", 32'(pattern), 32'h10);

        // Drop run exactly in the wrap cycle.
        n = 0;
        while (!(m_sel == 1 && m_age == TC - 1) && n < 50) begin
            cycle(1'b1);
            n++;
        end
        check_eq("reach_wrap", 32'(n < 50), 32'd1);
        saved = m_pos;
        cycle(1'b0);
        check_eq("wrapdrop_tick", 32'(tick), 32'd0);
        check_eq("wrapdrop_pos",  32'(pos),  32'(saved));
        repeat (3) cycle(1'b1);

        // Asynchronous reset mid-cycle at pos 6 sweeping down.
        n = 0;
        while (!(m_pos == 6 && m_dir == 1) && n < 300) begin
            cycle(1'b1);
            n++;
        end
        check_eq("reach_pos6_dn", 32'(n < 300), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * TC + 2) cycle(1'b1);

        // Randomized run/pause traffic.
        repeat (400) cycle($urandom_range(0, 9) != 0);

        // Full-size prescaler: first tick 10000 cycles after sel rises.
        check_eq("slow_sel_idle", 32'(sel2), 32'd0);
        @(negedge clk);
        run2 = 1'b1;
        @(posedge clk);
        #1;
        check_eq("slow_sel_rise", 32'(sel2), 32'd1);
        n = 0;
        while (tick2 !== 1'b1 && n < 10100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("slow_tick_latency", 32'(n), 32'd10000);
        check_eq("slow_pos_after", 32'(pos2), 32'd1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
